// File: rtl/integration_pkg.sv
// integration_pkg: shared AHB-lite types, slave address map and responder FSM state encoding.
// Provides transfer_t, rw_t, size_t, resp_t, burst_t, MAX_SLAVE, slave_low_address/slave_high_address,
// ahb_resp_state_t with its S_* constants, and lane_mask() for little-endian byte-lane selection.
package integration_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} transfer_t;
   typedef enum logic {READ = 1'b0, WRITE = 1'b1} rw_t;
   typedef enum logic [2:0] {BYTE = 3'd0, HALFWORD = 3'd1, WORD = 3'd2, DWORD = 3'd3,
                             W128 = 3'd4, W256 = 3'd5, W512 = 3'd6, W1024 = 3'd7} size_t;
   typedef enum logic [1:0] {OKAY = 2'd0, ERROR = 2'd1, RETRY = 2'd2, SPLIT = 2'd3} resp_t;
   typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} burst_t;
   localparam int MAX_SLAVE = 4;
   localparam logic [31:0] slave_low_address [MAX_SLAVE] = '{32'd0, 32'd32, 32'd64, 32'd96};
   localparam logic [31:0] slave_high_address [MAX_SLAVE] = '{32'd31, 32'd63, 32'd95, 32'd127};
   typedef logic [1:0] ahb_resp_state_t;
   localparam ahb_resp_state_t S_IDLE = 2'd0;
   localparam ahb_resp_state_t S_WAIT = 2'd1;
   localparam ahb_resp_state_t S_ERR1 = 2'd2;
   localparam ahb_resp_state_t S_ERR2 = 2'd3;
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
      return size == BYTE ? 4'b0001 << a : size == HALFWORD ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
   endfunction
endpackage

// File: rtl/ahb_byte_mem.sv
// ahb_byte_mem: MEM_WORDS x 32 storage with per-byte write enables and asynchronous read.
// Ports: clk, rst (sync, clears all words), we[3:0] byte enables, addr word index, wdata, rdata.
module ahb_byte_mem #(
   parameter int MEM_WORDS = 8,
   parameter int IW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    we,
   input  logic [IW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [MEM_WORDS];
   always_ff @(posedge clk)
      if (rst)
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
      else
         for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
   assign rdata = mem[addr];
endmodule

// File: rtl/ahb_slave_responder.sv
// ahb_slave_responder: AHB-lite memory slave with configurable wait states and two-cycle ERROR response.
// Ports: HCLK/HRESET (sync, active-high), HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HREADY address phase,
// HWDATA write data, HREADYOUT/HRESP/HRDATA slave response.
module ahb_slave_responder
   import integration_pkg::*;
#(
   parameter int SLAVE_ID = 0,
   parameter int WAIT_STATES = 0,
   parameter int MEM_WORDS = 8
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA
);
   localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
   localparam logic [31:0] LO = slave_low_address[SLAVE_ID];
   localparam logic [31:0] HI = slave_high_address[SLAVE_ID];
   ahb_resp_state_t state;
   logic [3:0]  cnt;
   logic        act, a_write, acc, err, done, unused;
   logic [2:0]  a_size;
   logic [31:0] a_addr, off_in, off_reg, rdata;
   logic [3:0]  we;
   // HTRANS[1] set means NONSEQ or SEQ
   assign acc = HSEL && HREADY && HREADYOUT && HTRANS[1];
   assign off_in = HADDR - LO;
   assign err = HADDR < LO || HADDR > HI || HSIZE > WORD ||
                (HSIZE == HALFWORD && HADDR[0]) || (HSIZE == WORD && |HADDR[1:0]) ||
                (off_in >> 2) >= 32'(MEM_WORDS);
   // act marks an accepted OKAY transfer; it completes in the first S_IDLE cycle after acceptance/waits
   assign done = state == S_IDLE && act;
   assign off_reg = a_addr - LO;
   assign we = done && a_write ? lane_mask(a_size, a_addr[1:0]) : 4'b0;
   assign HREADYOUT = state == S_IDLE || state == S_ERR2;
   assign HRESP = state == S_ERR1 || state == S_ERR2 ? ERROR : OKAY;
   assign HRDATA = done && !a_write ? rdata : 32'd0;
   assign unused = ^{HBURST, off_reg};
   always_ff @(posedge HCLK)
      if (HRESET) begin
         state <= S_IDLE;
         cnt <= '0;
         act <= 1'b0;
         a_addr <= '0;
         a_write <= 1'b0;
         a_size <= '0;
      end else if (HREADYOUT) begin
         act <= acc && !err;
         cnt <= acc && !err ? 4'(WAIT_STATES) : 4'd0;
         state <= !acc ? S_IDLE : err ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_IDLE;
         if (acc) begin
            a_addr <= HADDR;
            a_write <= HWRITE;
            a_size <= HSIZE;
         end
      end else if (state == S_WAIT) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) state <= S_IDLE;
      end else
         state <= S_ERR2;
   ahb_byte_mem #(.MEM_WORDS(MEM_WORDS), .IW(IW)) u_mem (
      .clk(HCLK),
      .rst(HRESET),
      .we(we),
      .addr(off_reg[IW+1:2]),
      .wdata(HWDATA),
      .rdata(rdata)
   );
endmodule

// File: tb/tb_ahb_slave_responder.sv
// tb_ahb_slave_responder: directed checks of three responders (0, 2 and 3 wait states) in window 64..95.
module tb_ahb_slave_responder;
   logic        clk = 0, rst = 0, sel0 = 0, sel2 = 0, sel3 = 0, hwrite = 0;
   logic [31:0] haddr = 0, hwdata = 0;
   logic [1:0]  htrans = 0;
   logic [2:0]  hsize = 0, hburst = 0;
   logic        rdy0, rdy2, rdy3;
   logic [1:0]  resp0, resp2, resp3;
   logic [31:0] rd0, rd2, rd3;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   ahb_slave_responder #(.SLAVE_ID(2), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy0),
      .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));
   ahb_slave_responder #(.SLAVE_ID(2), .WAIT_STATES(2)) dut2 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy2),
      .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rd2));
   ahb_slave_responder #(.SLAVE_ID(2), .WAIT_STATES(3)) dut3 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy3),
      .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rd3));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic addr_ph(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] s);
      htrans = t;
      haddr = a;
      hwrite = w;
      hsize = s;
   endtask

   task automatic test_reset;
      rst = 1;
      tick;
      tick;
      rst = 0;
      n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL rst_rdy0 got %0b want 1", rdy0); end
      n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL rst_rdy2 got %0b want 1", rdy2); end
      n_cmp++; if (resp3 !== 2'd0) begin n_bad++; $display("FAIL rst_resp3 got %0d want 0", resp3); end
      n_cmp++; if (rd0 !== 32'd0) begin n_bad++; $display("FAIL rst_rdata0 got %h want 0", rd0); end
   endtask

   task automatic test_write_read;
      sel0 = 1;
      addr_ph(2'd2, 32'd68, 1'b1, 3'd2);
      tick;
      n_cmp++; if (rdy0 !== 1'b1 || resp0 !== 2'd0) begin n_bad++; $display("FAIL wr_phase got rdy=%0b resp=%0d want 1/0", rdy0, resp0); end
      hwdata = 32'hDEADBEEF;
      addr_ph(2'd2, 32'd68, 1'b0, 3'd2);
      tick;
      n_cmp++; if (rdy0 !== 1'b1 || resp0 !== 2'd0) begin n_bad++; $display("FAIL rd_phase got rdy=%0b resp=%0d want 1/0", rdy0, resp0); end
      n_cmp++; if (rd0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_b2b got %h want deadbeef", rd0); end
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      tick;
      n_cmp++; if (rd0 !== 32'd0) begin n_bad++; $display("FAIL rd_idle_zero got %h want 0", rd0); end
   endtask

   task automatic test_byte_lane;
      addr_ph(2'd2, 32'd70, 1'b1, 3'd0);
      tick;
      hwdata = 32'h11AB2233;
      addr_ph(2'd2, 32'd68, 1'b0, 3'd2);
      tick;
      n_cmp++; if (rd0 !== 32'hDEABBEEF) begin n_bad++; $display("FAIL byte_lane got %h want deabbeef", rd0); end
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      tick;
   endtask

   task automatic test_error(input logic [31:0] a, input logic [2:0] s, input logic w, input string nm);
      addr_ph(2'd2, a, w, s);
      tick;
      n_cmp++; if (rdy0 !== 1'b0 || resp0 !== 2'd1) begin n_bad++; $display("FAIL %s_err1 got rdy=%0b resp=%0d want 0/1", nm, rdy0, resp0); end
      n_cmp++; if (rd0 !== 32'd0) begin n_bad++; $display("FAIL %s_err1_data got %h want 0", nm, rd0); end
      hwdata = 32'hFFFFFFFF;
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      tick;
      n_cmp++; if (rdy0 !== 1'b1 || resp0 !== 2'd1) begin n_bad++; $display("FAIL %s_err2 got rdy=%0b resp=%0d want 1/1", nm, rdy0, resp0); end
      addr_ph(2'd2, 32'd68, 1'b0, 3'd2);
      tick;
      n_cmp++; if (rdy0 !== 1'b1 || resp0 !== 2'd0) begin n_bad++; $display("FAIL %s_after got rdy=%0b resp=%0d want 1/0", nm, rdy0, resp0); end
      n_cmp++; if (rd0 !== 32'hDEABBEEF) begin n_bad++; $display("FAIL %s_unchanged got %h want deabbeef", nm, rd0); end
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      tick;
   endtask

   task automatic test_busy;
      addr_ph(2'd2, 32'd64, 1'b1, 3'd2);
      tick;
      hwdata = 32'hA5A5A5A5;
      addr_ph(2'd1, 32'd68, 1'b0, 3'd2);
      tick;
      n_cmp++; if (rdy0 !== 1'b1 || resp0 !== 2'd0 || rd0 !== 32'd0) begin n_bad++; $display("FAIL busy_phase got rdy=%0b resp=%0d data=%h want 1/0/0", rdy0, resp0, rd0); end
      addr_ph(2'd3, 32'd68, 1'b0, 3'd2);
      tick;
      n_cmp++; if (rd0 !== 32'hDEABBEEF) begin n_bad++; $display("FAIL seq_read got %h want deabbeef", rd0); end
      addr_ph(2'd2, 32'd64, 1'b0, 3'd2);
      tick;
      n_cmp++; if (rd0 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL nonseq_write got %h want a5a5a5a5", rd0); end
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      tick;
      sel0 = 0;
   endtask

   task automatic test_wait_states;
      sel2 = 1;
      addr_ph(2'd2, 32'd64, 1'b1, 3'd2);
      tick;
      hwdata = 32'h12345678;
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      n_cmp++; if (rdy2 !== 1'b0) begin n_bad++; $display("FAIL ws_w1 got %0b want 0", rdy2); end
      tick;
      n_cmp++; if (rdy2 !== 1'b0) begin n_bad++; $display("FAIL ws_w2 got %0b want 0", rdy2); end
      tick;
      n_cmp++; if (rdy2 !== 1'b1 || resp2 !== 2'd0) begin n_bad++; $display("FAIL ws_w3 got rdy=%0b resp=%0d want 1/0", rdy2, resp2); end
      addr_ph(2'd2, 32'd64, 1'b0, 3'd2);
      tick;
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      n_cmp++; if (rdy2 !== 1'b0 || rd2 !== 32'd0) begin n_bad++; $display("FAIL ws_r1 got rdy=%0b data=%h want 0/0", rdy2, rd2); end
      tick;
      n_cmp++; if (rdy2 !== 1'b0) begin n_bad++; $display("FAIL ws_r2 got %0b want 0", rdy2); end
      tick;
      n_cmp++; if (rdy2 !== 1'b1 || rd2 !== 32'h12345678) begin n_bad++; $display("FAIL ws_r3 got rdy=%0b data=%h want 1/12345678", rdy2, rd2); end
      tick;
      sel2 = 0;
      sel0 = 1;
      addr_ph(2'd2, 32'd64, 1'b0, 3'd2);
      tick;
      n_cmp++; if (rd0 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL hsel_low_ignored got %h want a5a5a5a5", rd0); end
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      tick;
      sel0 = 0;
   endtask

   task automatic test_reset_abort;
      sel3 = 1;
      addr_ph(2'd2, 32'd72, 1'b1, 3'd2);
      tick;
      n_cmp++; if (rdy3 !== 1'b0) begin n_bad++; $display("FAIL abort_wait got %0b want 0", rdy3); end
      hwdata = 32'hCAFEF00D;
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      rst = 1;
      tick;
      rst = 0;
      n_cmp++; if (rdy3 !== 1'b1 || resp3 !== 2'd0) begin n_bad++; $display("FAIL abort_ready got rdy=%0b resp=%0d want 1/0", rdy3, resp3); end
      addr_ph(2'd2, 32'd72, 1'b0, 3'd2);
      tick;
      addr_ph(2'd0, 32'd0, 1'b0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (rdy3 !== 1'b0) begin n_bad++; $display("FAIL abort_rd_wait%0d got %0b want 0", i, rdy3); end
         tick;
      end
      n_cmp++; if (rdy3 !== 1'b1 || rd3 !== 32'd0) begin n_bad++; $display("FAIL abort_read got rdy=%0b data=%h want 1/0", rdy3, rd3); end
      tick;
      sel3 = 0;
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_byte_lane;
      test_error(32'd96, 3'd2, 1'b0, "out_of_range");
      test_error(32'd69, 3'd1, 1'b0, "misaligned_half");
      test_error(32'd64, 3'd3, 1'b0, "oversize");
      test_error(32'd70, 3'd2, 1'b1, "misaligned_write");
      test_busy;
      test_wait_states;
      test_reset_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
